// File: rtl/rect_flip_decoder.sv
// rect_flip_decoder: inverse/checker for the rectangle corner-flip block.
// Registers m_orig ^ m_flip on start, scans one row per clock and recovers
// the rectangle (r1, r2, c1, c2) whose four corners were flipped, or reports
// the pair as not a legal single-rectangle flip (valid=0, coordinates 0).
// Optional feature macro: RECT_DEC_EARLY_ABORT_EN -- stop scanning on the
// first row that proves the difference illegal.
module rect_flip_decoder #(
  parameter  int ROWS = 8,
  parameter  int COLS = 8,
  localparam int RW   = $clog2(ROWS),
  localparam int CW   = $clog2(COLS),
  localparam int NW   = $clog2(ROWS*COLS+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] m_orig,
  input  logic [ROWS*COLS-1:0] m_flip,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic [RW-1:0]        r1,
  output logic [RW-1:0]        r2,
  output logic [CW-1:0]        c1,
  output logic [CW-1:0]        c2,
  output logic [NW-1:0]        diff_count
);

  localparam int PW = $clog2(COLS+1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state_q, state_d;
  logic [ROWS*COLS-1:0] diff_q;
  logic [RW-1:0]        row_q;
  logic [1:0]           found_q, found_d;
  logic                 err_q, err_d;
  logic [COLS-1:0]      row_bits;
  logic [PW-1:0]        p;
  logic [CW-1:0]        lo, hi;
  logic [NW-1:0]        count_d;
  logic [RW-1:0]        r1_d, r2_d;
  logic [CW-1:0]        c1_d, c2_d;
  logic                 last_row, valid_d;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // Row statistics of the current scan row: popcount and lowest/highest set column.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    row_bits = diff_q[row_q*COLS +: COLS];
    p  = '0;
    lo = '0;
    hi = '0;
    for (int c = COLS-1; c >= 0; c--) begin
      if (row_bits[c]) lo = CW'(c);
    end
    for (int c = 0; c < COLS; c++) begin
      if (row_bits[c]) begin
        hi = CW'(c);
        p  = p + PW'(1);
      end
    end
  end

  // Scan bookkeeping and next-state decision.
  always_comb begin
    state_d  = state_q;
    found_d  = found_q;
    err_d    = err_q;
    r1_d     = r1;
    r2_d     = r2;
    c1_d     = c1;
    c2_d     = c2;
    count_d  = diff_count + NW'(p);
    last_row = (row_q == RW'(ROWS-1));

    if (p == PW'(2)) begin
      case (found_q)
        2'd0: begin
          r1_d    = row_q;
          c1_d    = lo;
          c2_d    = hi;
          found_d = 2'd1;
        end
        2'd1: begin
          if (lo == c1 && hi == c2) begin
            r2_d    = row_q;
            found_d = 2'd2;
          end else begin
            err_d = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end else if (p != '0) begin
      err_d = 1'b1;
    end

    valid_d = !err_d && (found_d == 2'd2) && (count_d == NW'(4));

    case (state_q)
      IDLE: if (start) state_d = SCAN;
      SCAN: begin
`ifdef RECT_DEC_EARLY_ABORT_EN
        if (last_row || err_d) state_d = DONE;
`else
        if (last_row) state_d = DONE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, scan registers and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the diff store is reset too: it is a plain register bank, not a RAM, and reset must leave no stale difference behind.
      state_q    <= IDLE;
      diff_q     <= '0;
      row_q      <= '0;
      found_q    <= '0;
      err_q      <= 1'b0;
      valid      <= 1'b0;
      r1         <= '0;
      r2         <= '0;
      c1         <= '0;
      c2         <= '0;
      diff_count <= '0;
    end else begin
      // NOTE: non-blocking everywhere here; a later assignment in the same branch overrides an earlier one.
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            diff_q     <= m_orig ^ m_flip;
            row_q      <= '0;
            found_q    <= '0;
            err_q      <= 1'b0;
            valid      <= 1'b0;
            r1         <= '0;
            r2         <= '0;
            c1         <= '0;
            c2         <= '0;
            diff_count <= '0;
          end
        end
        SCAN: begin
          row_q      <= row_q + RW'(1);
          found_q    <= found_d;
          err_q      <= err_d;
          diff_count <= count_d;
          r1         <= r1_d;
          r2         <= r2_d;
          c1         <= c1_d;
          c2         <= c2_d;
          if (state_d == DONE) begin
            valid <= valid_d;
            if (!valid_d) begin
              r1 <= '0;
              r2 <= '0;
              c1 <= '0;
              c2 <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_flip_decoder.sv
// Randomized self-checking bench for rect_flip_decoder against a reference
// model that classifies the difference from its list of set bit positions.
module tb_rect_flip_decoder;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int N    = ROWS*COLS;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int NW   = $clog2(N+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  m_orig = '0;
  logic [N-1:0]  m_flip = '0;
  logic          busy, done, valid;
  logic [RW-1:0] r1, r2;
  logic [CW-1:0] c1, c2;
  logic [NW-1:0] diff_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int valid;
    int r1, r2, c1, c2;
    int count;
    int lat;
  } exp_t;

  rect_flip_decoder #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m_orig(m_orig), .m_flip(m_flip),
    .busy(busy), .done(done), .valid(valid), .r1(r1), .r2(r2), .c1(c1), .c2(c2),
    .diff_count(diff_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: a legal flip is exactly four differing bits forming the corners
  // of a rectangle with two distinct rows and two distinct columns.
  function automatic exp_t model(input logic [N-1:0] d);
    exp_t e;
    int   pos[$];
    e = '{valid: 0, r1: 0, r2: 0, c1: 0, c2: 0, count: 0, lat: ROWS+1};
    for (int i = 0; i < N; i++) if (d[i]) pos.push_back(i);
    e.count = pos.size();
    if (pos.size() == 4) begin
      if (pos[0]/COLS == pos[1]/COLS && pos[2]/COLS == pos[3]/COLS &&
          pos[0]/COLS < pos[2]/COLS &&
          pos[0]%COLS == pos[2]%COLS && pos[1]%COLS == pos[3]%COLS) begin
        e.valid = 1;
        e.r1 = pos[0]/COLS; e.r2 = pos[2]/COLS;
        e.c1 = pos[0]%COLS; e.c2 = pos[1]%COLS;
      end
    end
`ifdef RECT_DEC_EARLY_ABORT_EN
    begin
      int pairs = 0, pc1 = 0, pc2 = 0, run = 0;
      for (int r = 0; r < ROWS; r++) begin
        int cnt = 0, lo = -1, hi = -1;
        bit bad;
        for (int c = 0; c < COLS; c++) if (d[r*COLS+c]) begin
          cnt++; if (lo < 0) lo = c; hi = c;
        end
        run += cnt;
        bad = (cnt != 0 && cnt != 2) ||
              (cnt == 2 && (pairs == 2 || (pairs == 1 && (lo != pc1 || hi != pc2))));
        if (bad) begin
          e = '{valid: 0, r1: 0, r2: 0, c1: 0, c2: 0, count: run, lat: r+2};
          break;
        end
        if (cnt == 2) begin
          if (pairs == 0) begin pc1 = lo; pc2 = hi; end
          pairs++;
        end
      end
    end
`endif
    return e;
  endfunction

  // One transaction: start at cycle 0, optional extra starts while busy,
  // optional start coincident with DONE; checks latency and held results.
  task automatic run_case(input string tag, input logic [N-1:0] o, input logic [N-1:0] f,
                          input bit poke_busy, input bit poke_done);
    exp_t e;
    int   cyc;
    e = model(o ^ f);
    m_orig = o; m_flip = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_orig = ~o;                    // inputs must not be resampled mid-scan
    m_flip = $urandom();
    cyc = 1;
    check({tag, ".busy1"}, busy, 1);
    while (!done && cyc < 40) begin
      start = poke_busy && (cyc == 3 || cyc == 5);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, ".lat"}, cyc, e.lat);
    check({tag, ".valid"}, valid, e.valid);
    check({tag, ".coords"}, {r1, r2, c1, c2}, {RW'(e.r1), RW'(e.r2), CW'(e.c1), CW'(e.c2)});
    check({tag, ".count"}, diff_count, e.count);
    start = poke_done;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".idle"}, {busy, done}, 0);
    @(posedge clk); #1;
    check({tag, ".hold"}, {busy, valid, r1, r2, c1, c2, diff_count},
          {1'b0, 1'(e.valid), RW'(e.r1), RW'(e.r2), CW'(e.c1), CW'(e.c2), NW'(e.count)});
  endtask

  function automatic logic [N-1:0] bits4(input int a, input int b, input int c, input int d);
    logic [N-1:0] v = '0;
    v[a] = 1'b1; v[b] = 1'b1; v[c] = 1'b1; v[d] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [N-1:0] base, d;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {busy, done, valid, r1, r2, c1, c2, diff_count}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_case("rect", '0, bits4(10, 13, 42, 45), 1'b0, 1'b0);
    base = {$urandom(), $urandom()};
    run_case("same", base, base, 1'b0, 1'b1);
    run_case("colmis", '0, bits4(10, 13, 42, 46), 1'b0, 1'b0);
    d = bits4(10, 13, 42, 45); d[60] = 1'b1;
    run_case("five", '0, d, 1'b1, 1'b0);
    base = {$urandom(), $urandom()};
    run_case("corners", base, base ^ bits4(0, 7, 56, 63), 1'b0, 1'b0);

    // Reset in the middle of a scan.
    m_orig = '0; m_flip = bits4(10, 13, 42, 45);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("midrst", {busy, done, valid, r1, r2, c1, c2, diff_count}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_case("postrst", '0, bits4(9, 14, 49, 54), 1'b0, 1'b0);

    // Random: legal rectangles, degenerate rectangles and sparse random flips.
    for (int k = 0; k < 24; k++) begin
      int ra, rb, ca, cb;
      base = {$urandom(), $urandom()};
      ra = $urandom_range(0, ROWS-1); rb = $urandom_range(0, ROWS-1);
      ca = $urandom_range(0, COLS-1); cb = $urandom_range(0, COLS-1);
      case (k % 3)
        0: begin
          if (ra == rb) rb = (ra + 1) % ROWS;
          if (ca == cb) cb = (ca + 1) % COLS;
          d = '0;
          d[ra*COLS+ca] = 1'b1; d[ra*COLS+cb] = 1'b1;
          d[rb*COLS+ca] = 1'b1; d[rb*COLS+cb] = 1'b1;
        end
        1: begin
          d = '0;   // corners XORed in place: degenerate shapes cancel
          d[ra*COLS+ca] ^= 1'b1; d[ra*COLS+cb] ^= 1'b1;
          d[rb*COLS+ca] ^= 1'b1; d[rb*COLS+cb] ^= 1'b1;
          d[$urandom_range(0, N-1)] ^= ($urandom_range(0, 1) == 1);
        end
        default: begin
          d = '0;
          repeat ($urandom_range(1, 6)) d[$urandom_range(0, N-1)] = 1'b1;
        end
      endcase
      run_case($sformatf("rnd%0d", k), base, base ^ d, k[0], k[1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rect_flip_decoder.md
Name: rect_flip_decoder

Overview:
- Decoder companion to the rectangle corner-flip block.
- Given an original matrix and a candidate flipped matrix, it XORs them and scans the difference one row per clock.
- It recovers the rectangle coordinates (r1, r2, c1, c2) whose four corner bits were flipped, or flags the pair as not a valid single-rectangle flip.
- Sits downstream of the flipper in the rectangle-loop datapath as its checker/inverse.

Parameters:
- ROWS, 8, matrix row count (>=2).
- COLS, 8, matrix column count (>=2).
- RW, $clog2(ROWS), row index width (derived, do not override).
- CW, $clog2(COLS), column index width (derived, do not override).
- NW, $clog2(ROWS*COLS+1), difference-count width (derived).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- m_orig  in  ROWS*COLS  original matrix, flat; bit index = row*COLS + col.
- m_flip  in  ROWS*COLS  flipped matrix, same layout.
- busy  out  1  high in SCAN and DONE states.
- done  out  1  one-cycle pulse when result is ready.
- valid  out  1  result is a legal rectangle flip; held until next start.
- r1  out  RW  top corner row (r1 < r2).
- r2  out  RW  bottom corner row.
- c1  out  CW  left corner column (c1 < c2).
- c2  out  CW  right corner column.
- diff_count  out  NW  number of differing bits seen during scan.

Behaviour:
- Reset (any time, including mid-scan): state=IDLE; busy=0, done=0, valid=0, r1=r2=c1=c2=0, diff_count=0; internal diff register and row counter cleared.
- States: IDLE -> SCAN -> DONE -> IDLE.
- IDLE, start=1:
  - Register diff = m_orig ^ m_flip; row counter=0; clear found-rows count, error flag and diff_count.
  - Go to SCAN. Inputs are not sampled again until the next start.
- SCAN, one row per cycle at current row r. Compute row popcount p and lowest/highest set columns lo/hi, then:
  - p == 0: no action.
  - p == 2, found-rows == 0: capture r1=r, c1=lo, c2=hi; found-rows=1.
  - p == 2, found-rows == 1: if lo==c1 and hi==c2, capture r2=r and set found-rows=2; else set error.
  - p == 2, found-rows == 2: set error.
  - p not 0 and not 2: set error.
  - diff_count += p every SCAN cycle (saturates never; width sized for all bits).
  - When r == ROWS-1, go to DONE; otherwise r++.
- DONE (one cycle):
  - done=1.
  - valid = (!error && found-rows==2 && diff_count==4).
  - If valid=0, drive r1/r2/c1/c2 to 0. diff_count always reports the scanned total.
  - Next state IDLE.
- Latency: start at cycle 0 -> done high at cycle ROWS+1 (9 for default). busy is high in cycles 1..ROWS+1.
- Outputs hold from DONE until the next accepted start. At that start they clear to 0 on the next edge.
- start while busy: ignored, no queueing.
- start coincident with DONE: ignored; a new start is accepted from IDLE only.
- Identical matrices: valid=0, diff_count=0, done still pulses.
- Corner case: a rectangle with r1==r2 or c1==c2 cannot produce a legal diff (the flips cancel or give p != 2), so the result is valid=0.

Optional Feature:
- Macro: RECT_DEC_EARLY_ABORT_EN.
- Defined: the first cycle that sets error goes directly to DONE the next cycle. The DONE cycle reports valid=0 and the partial diff_count, so done latency for invalid inputs is shorter than ROWS+1.
- Undefined: the scan always runs all ROWS rows; latency is fixed at ROWS+1 and diff_count is the full-matrix count.

Test Plan:
- m_orig=0, m_flip has bits at idx 10, 13, 42, 45 (r1=1, c1=2, c2=5, r2=5); start -> done at cycle 9, valid=1, r1=1, r2=5, c1=2, c2=5, diff_count=4.
- m_orig=m_flip=random; start -> done at cycle 9, valid=0, all coords 0, diff_count=0.
- Diffs at idx 10, 13, 42, 46 (column mismatch in row 5) -> valid=0, diff_count=4; with RECT_DEC_EARLY_ABORT_EN, done at cycle 7 (error seen at row 5).
- Diffs at idx 10, 13, 42, 45, 60 (five bits) -> valid=0, diff_count=5; start pulsed again at cycles 3 and 5 -> ignored, done still at cycle 9 only.
- Valid case at idx 0, 7, 56, 63 (full-extent corners) -> valid=1, r1=0, r2=7, c1=0, c2=7.
- rst_n low at cycle 4 of a scan -> all outputs 0 immediately; a new start after release produces a normal result at start+9.
